seq_alu: RTL
============

# seq_alu

Parametrised, registered arithmetic unit for the matrix-multiply datapath. It accepts one operation at a time over a valid/ready handshake. Add, sub, pass and logic ops complete in one cycle. Multiply and divide run as WIDTH-cycle iterative shift-add and restoring-divide loops. It returns a full-width result, a high word (product high half or remainder) and status flags, and feeds the accumulator/register-file writeback path.

## Interface
- WIDTH, 16: operand/result width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH+1): iteration counter width; derived, not overridden.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit idle and able to accept
- alu_op  in  3  0 add, 1 sub, 2 mul, 3 div, 4 pass in2, 5 and, 6 or, 7 xor
- in1, in2  in  WIDTH  operands, unsigned
- out_valid  out  1  one-cycle pulse: result/flags updated this cycle
- result  out  WIDTH  sum/difference/product low/quotient/pass/logic
- result_hi  out  WIDTH  product high half (mul), remainder (div), 0 otherwise
- z  out  1  result == 0
- c  out  1  carry (add), borrow in1<in2 (sub), result_hi != 0 (mul), 0 otherwise
- dz  out  1  divide by zero (div with in2 == 0), 0 otherwise

## Operation
- Reset state: IDLE.
- Output reset values: in_ready=1, out_valid=0, result=0, result_hi=0, z=1, c=0, dz=0.
- States: IDLE, MUL, DIV.
- Accept on rising edge with in_valid && in_ready. alu_op and operands are captured; later changes on the inputs are ignored.
- IDLE, single-cycle op (0,1,4,5,6,7) or div with in2==0:
  - outputs are registered on the accept edge;
  - out_valid is high the following cycle;
  - state stays IDLE.
- IDLE, mul: load multiplicand, multiplier and a 2·WIDTH accumulator. Clear the counter. Go to MUL.
- MUL: each cycle, add the multiplicand to the accumulator high half if multiplier LSB=1, then shift right 1. After WIDTH iterations:
  - register {result_hi,result} = in1*in2 exactly (2·WIDTH bits, no truncation);
  - pulse out_valid;
  - return to IDLE.
- IDLE, div with in2≠0: load dividend and divisor, clear the remainder. Go to DIV.
- DIV: restoring division, one quotient bit per cycle, MSB first. After WIDTH iterations:
  - register result=in1/in2 and result_hi=in1%in2;
  - pulse out_valid;
  - return to IDLE.
- Divide by zero: result={WIDTH{1}}, result_hi=in1, dz=1, z=0, c=0. Single-cycle latency.
- Add/sub wrap modulo 2^WIDTH. c holds the carry-out or the borrow.
- z is computed from the registered result only, not from result_hi.
- result, result_hi and flags hold their values between out_valid pulses.
- in_ready=0 in MUL/DIV. Requests presented while busy are not accepted; the requester holds in_valid.
- A new request may be accepted in the same cycle out_valid is high for a single-cycle op, giving back-to-back one-per-cycle throughput.
- rst_n low at any time, including mid-MUL/DIV:
  - the in-flight op is abandoned and no out_valid is produced;
  - all outputs return to their reset values asynchronously.

## Timing
- Latency, accept edge to out_valid: single-cycle ops and div-by-zero 1 cycle; mul and div WIDTH+1 cycles.
- in_ready is low for WIDTH cycles after a mul/div accept and returns high in the out_valid cycle. A new op may be accepted on the edge ending that cycle.
- Throughput: single-cycle ops 1/cycle; mul and div 1 per WIDTH+1 cycles.
- out_valid is never high for two consecutive cycles from one op.
- Reset is asserted asynchronously and released synchronously by the environment. The first accept is possible on the first edge after release.

## Test plan
- Reset: hold rst_n=0 -> in_ready=1, out_valid=0, result=0, result_hi=0, z=1, c=0, dz=0. Pull rst_n low mid-MUL -> outputs reset immediately and no out_valid follows.
- Single-cycle ops, WIDTH=16:
  - add 0xFFFF+0x0001 -> result=0x0000, z=1, c=1, out_valid 1 cycle after accept;
  - sub 3-5 -> result=0xFFFE, c=1;
  - xor 0xAAAA^0xAAAA -> z=1;
  - back-to-back accepts on consecutive edges give consecutive out_valid pulses.
- Mul: 0xFFFF*0xFFFF -> result=0x0001, result_hi=0xFFFE, c=1, out_valid exactly 17 cycles after accept. in_ready=0 for 16 cycles.
- Div: 1000/7 -> result=142, result_hi=6, dz=0, latency 17. Also 5/9 -> result=0, result_hi=5, z=1.
- Div by zero: 0x1234/0 -> result=0xFFFF, result_hi=0x1234, dz=1, latency 1.
- Busy backpressure: hold in_valid=1 with add 1+1 during a mul -> not accepted until in_ready=1. Add result 2 appears 1 cycle after the mul out_valid edge accept. Mul result is not corrupted.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered arithmetic unit with single-cycle add/sub/logic ops and
// WIDTH-cycle iterative shift-add multiply and restoring divide.
module seq_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             z,
    output logic             c,
    output logic             dz
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned W2    = 2 * WIDTH;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_PASS = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    // Multiplicand (mul) or divisor (div), captured at accept.
    logic [WIDTH-1:0]   mcand;
    // Mul: {product high, multiplier/product low}. Div: {remainder, dividend/quotient}.
    logic [W2-1:0]      acc;

    logic [WIDTH-1:0]   op_res;
    logic               op_c;

    logic [WIDTH:0]     mul_sum;
    logic [W2-1:0]      mul_next;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [W2-1:0]      div_next;

    // Single-cycle operations on the raw inputs, used on the accept edge.
    always_comb begin
        op_res = '0;
        op_c   = 1'b0;
        case (alu_op)
            OP_ADD:  {op_c, op_res} = {1'b0, in1} + {1'b0, in2};
            OP_SUB:  {op_c, op_res} = {1'b0, in1} - {1'b0, in2};
            OP_PASS: op_res = in2;
            OP_AND:  op_res = in1 & in2;
            OP_OR:   op_res = in1 | in2;
            OP_XOR:  op_res = in1 ^ in2;
            default: begin
                op_res = '0;
                op_c   = 1'b0;
            end
        endcase
    end

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        // Remainder shifted left with the next dividend bit; never exceeds 2*divisor-1.
        div_trial = acc[W2-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, mcand};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            z         <= 1'b1;
            c         <= 1'b0;
            dz        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        case (alu_op)
                            OP_MUL: begin
                                mcand    <= in1;
                                acc      <= {{WIDTH{1'b0}}, in2};
                                cnt      <= '0;
                                in_ready <= 1'b0;
                                state    <= S_MUL;
                            end
                            OP_DIV: begin
                                if (in2 == '0) begin
                                    result    <= '1;
                                    result_hi <= in1;
                                    z         <= 1'b0;
                                    c         <= 1'b0;
                                    dz        <= 1'b1;
                                    out_valid <= 1'b1;
                                end else begin
                                    mcand    <= in2;
                                    acc      <= {{WIDTH{1'b0}}, in1};
                                    cnt      <= '0;
                                    in_ready <= 1'b0;
                                    state    <= S_DIV;
                                end
                            end
                            default: begin
                                result    <= op_res;
                                result_hi <= '0;
                                z         <= (op_res == '0);
                                c         <= op_c;
                                dz        <= 1'b0;
                                out_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result    <= mul_next[WIDTH-1:0];
                        result_hi <= mul_next[W2-1:WIDTH];
                        z         <= (mul_next[WIDTH-1:0] == '0);
                        c         <= (mul_next[W2-1:WIDTH] != '0);
                        dz        <= 1'b0;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result    <= div_next[WIDTH-1:0];
                        result_hi <= div_next[W2-1:WIDTH];
                        z         <= (div_next[WIDTH-1:0] == '0);
                        c         <= 1'b0;
                        dz        <= 1'b0;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
